// File: rtl/delay_elastic.sv
// Elastic multi-stage delay line with valid/ready at both ends.
// Stalls only the blocked stages; bubbles ahead of a word are squeezed out.
module delay_elastic #(
  parameter int               WIDTH = 32,
  parameter int               DEPTH = 2,
  parameter logic [WIDTH-1:0] RESET = '0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] ONE = CW'(1);

  if (DEPTH < 1) begin : g_bad_depth
    $error("delay_elastic: DEPTH must be >= 1");
  end

  logic [DEPTH-1:0] r_v;
  logic [WIDTH-1:0] r_d [DEPTH];
  logic [CW-1:0]    r_cnt;
  logic [DEPTH-1:0] w_mv;
  logic             w_in_x;
  logic             w_out_x;

  // Walk back from the output: a stage may move if it is empty,
  // if the stage ahead is empty, or if the stage ahead moves too.
  always_comb begin
    w_mv = '0;
    w_mv[DEPTH-1] = !r_v[DEPTH-1] | out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      w_mv[i] = !r_v[i] | !r_v[i+1] | w_mv[i+1];
    end
  end

  assign w_in_x  = in_valid & w_mv[0];
  assign w_out_x = r_v[DEPTH-1] & out_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_v   <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_d[i] <= RESET;
      end
    end else if (flush) begin
      r_v   <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_d[i] <= RESET;
      end
    end else begin
      if (w_mv[0]) begin
        r_v[0] <= in_valid;
      end
      if (w_in_x) begin
        r_d[0] <= in_data;
      end
      // Data follows only a valid word, so empty stages keep old data.
      for (int i = 1; i < DEPTH; i++) begin
        if (w_mv[i]) begin
          r_v[i] <= r_v[i-1] & w_mv[i-1];
        end
        if (w_mv[i] & r_v[i-1]) begin
          r_d[i] <= r_d[i-1];
        end
      end
      case ({w_in_x, w_out_x})
        2'b10:   r_cnt <= r_cnt + ONE;
        2'b01:   r_cnt <= r_cnt - ONE;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign in_ready  = w_mv[0];
  assign out_valid = r_v[DEPTH-1];
  assign out_data  = r_d[DEPTH-1];
  assign count     = r_cnt;

endmodule

// File: tb/tb_delay_elastic.sv
// Bench for delay_elastic: DEPTH=3 and DEPTH=4 instances on shared
// inputs, checked against a word-position queue model.
module tb_delay_elastic;

  localparam logic [31:0] RV = 32'hA5A5_0001;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;

  logic        ir3, ov3, ir4, ov4;
  logic [31:0] od3, od4;
  logic [1:0]  cnt3;
  logic [2:0]  cnt4;

  always #5 clock = ~clock;

  delay_elastic #(.WIDTH(32), .DEPTH(3), .RESET(RV)) u3 (
    .clock(clock), .reset(reset), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(ir3),
    .out_data(od3), .out_valid(ov3), .out_ready(out_ready),
    .count(cnt3)
  );

  delay_elastic #(.WIDTH(32), .DEPTH(4), .RESET(RV)) u4 (
    .clock(clock), .reset(reset), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(ir4),
    .out_data(od4), .out_valid(ov4), .out_ready(out_ready),
    .count(cnt4)
  );

  int nvec = 0;
  int nmis = 0;

  // Model: per instance, a list of words (oldest first) with
  // their stage position; out_data is the last word to reach the end.
  int          md[2];
  int          mn[2];
  int          mpos[2][8];
  logic [31:0] mdat[2][8];
  logic [31:0] mlast[2];
  int          npos[2][8];
  bit          leave[2];
  bit          rdy[2];

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        fl;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_od;
    int          e_cnt;
  } vec_t;

  vec_t tv[23];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  task automatic mclear(input int k);
    mn[k]    = 0;
    mlast[k] = RV;
  endtask

  // Each word advances one place unless the word ahead ends
  // up right in front of it; the head leaves when out_ready.
  task automatic plan(input int k, input logic ordy);
    int lim;
    int np;
    lim = md[k] - 1;
    leave[k] = 0;
    for (int j = 0; j < mn[k]; j++) begin
      if (j == 0 && mpos[k][0] == md[k] - 1 && ordy) begin
        leave[k] = 1;
      end else begin
        np = mpos[k][j] + 1;
        if (np > lim) np = lim;
        npos[k][j] = np;
        lim = np - 1;
      end
    end
    rdy[k] = (lim >= 0);
  endtask

  task automatic commit(input int k, input logic iv,
                        input logic [31:0] id, input logic fl);
    int          n;
    int          tp[8];
    logic [31:0] td[8];
    if (fl) begin
      mclear(k);
      return;
    end
    n = 0;
    for (int j = 0; j < mn[k]; j++) begin
      if (!(j == 0 && leave[k])) begin
        tp[n] = npos[k][j];
        td[n] = mdat[k][j];
        n++;
      end
    end
    if (iv && rdy[k]) begin
      tp[n] = 0;
      td[n] = id;
      n++;
    end
    for (int j = 0; j < n; j++) begin
      mpos[k][j] = tp[j];
      mdat[k][j] = td[j];
    end
    mn[k] = n;
    if (n > 0 && tp[0] == md[k] - 1) mlast[k] = td[0];
  endtask

  task automatic mcheck(input int k);
    logic        ev;
    logic [31:0] aov, aod, air, acnt;
    ev = (mn[k] > 0) && (mpos[k][0] == md[k] - 1);
    aov  = (k == 0) ? 32'(ov3)  : 32'(ov4);
    aod  = (k == 0) ? od3       : od4;
    air  = (k == 0) ? 32'(ir3)  : 32'(ir4);
    acnt = (k == 0) ? 32'(cnt3) : 32'(cnt4);
    chk(k == 0 ? "m3.out_valid" : "m4.out_valid", aov, 32'(ev));
    chk(k == 0 ? "m3.out_data" : "m4.out_data", aod, mlast[k]);
    chk(k == 0 ? "m3.in_ready" : "m4.in_ready", air, 32'(rdy[k]));
    chk(k == 0 ? "m3.count" : "m4.count", acnt, 32'(mn[k]));
  endtask

  task automatic drive(input logic iv, input logic [31:0] id,
                       input logic ordy, input logic fl);
    @(negedge clock);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    #1;
    for (int k = 0; k < 2; k++) begin
      plan(k, ordy);
      mcheck(k);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    for (int k = 0; k < 2; k++) begin
      if (!reset) mclear(k);
      else commit(k, in_valid, in_data, flush);
    end
  endtask

  task automatic chk_rst();
    chk("rst3.out_valid", 32'(ov3), 32'd0);
    chk("rst3.out_data", od3, RV);
    chk("rst3.count", 32'(cnt3), 32'd0);
    chk("rst3.in_ready", 32'(ir3), 32'd1);
    chk("rst4.out_valid", 32'(ov4), 32'd0);
    chk("rst4.out_data", od4, RV);
    chk("rst4.count", 32'(cnt4), 32'd0);
    chk("rst4.in_ready", 32'(ir4), 32'd1);
  endtask

  initial begin
    md[0] = 3;
    md[1] = 4;
    mclear(0);
    mclear(1);

    tv[0]  = '{1'b1, 32'd1,  1'b1, 1'b0, 1'b1, 1'b0, RV,    0};
    tv[1]  = '{1'b1, 32'd2,  1'b1, 1'b0, 1'b1, 1'b0, RV,    1};
    tv[2]  = '{1'b1, 32'd3,  1'b1, 1'b0, 1'b1, 1'b0, RV,    2};
    tv[3]  = '{1'b1, 32'd4,  1'b1, 1'b0, 1'b1, 1'b1, 32'd1, 3};
    tv[4]  = '{1'b0, 32'd0,  1'b1, 1'b0, 1'b1, 1'b1, 32'd2, 3};
    tv[5]  = '{1'b0, 32'd0,  1'b1, 1'b0, 1'b1, 1'b1, 32'd3, 2};
    tv[6]  = '{1'b0, 32'd0,  1'b1, 1'b0, 1'b1, 1'b1, 32'd4, 1};
    tv[7]  = '{1'b0, 32'd0,  1'b0, 1'b0, 1'b1, 1'b0, 32'd4, 0};
    tv[8]  = '{1'b1, 32'd5,  1'b0, 1'b0, 1'b1, 1'b0, 32'd4, 0};
    tv[9]  = '{1'b1, 32'd6,  1'b0, 1'b0, 1'b1, 1'b0, 32'd4, 1};
    tv[10] = '{1'b1, 32'd7,  1'b0, 1'b0, 1'b1, 1'b0, 32'd4, 2};
    tv[11] = '{1'b1, 32'd8,  1'b0, 1'b0, 1'b0, 1'b1, 32'd5, 3};
    tv[12] = '{1'b1, 32'd8,  1'b0, 1'b0, 1'b0, 1'b1, 32'd5, 3};
    tv[13] = '{1'b1, 32'd8,  1'b1, 1'b0, 1'b1, 1'b1, 32'd5, 3};
    tv[14] = '{1'b1, 32'd9,  1'b1, 1'b0, 1'b1, 1'b1, 32'd6, 3};
    tv[15] = '{1'b0, 32'd0,  1'b1, 1'b0, 1'b1, 1'b1, 32'd7, 3};
    tv[16] = '{1'b0, 32'd0,  1'b1, 1'b0, 1'b1, 1'b1, 32'd8, 2};
    tv[17] = '{1'b0, 32'd0,  1'b1, 1'b0, 1'b1, 1'b1, 32'd9, 1};
    tv[18] = '{1'b0, 32'd0,  1'b1, 1'b0, 1'b1, 1'b0, 32'd9, 0};
    tv[19] = '{1'b1, 32'd10, 1'b0, 1'b0, 1'b1, 1'b0, 32'd9, 0};
    tv[20] = '{1'b1, 32'd11, 1'b0, 1'b0, 1'b1, 1'b0, 32'd9, 1};
    tv[21] = '{1'b1, 32'd12, 1'b0, 1'b1, 1'b1, 1'b0, 32'd9, 2};
    tv[22] = '{1'b0, 32'd0,  1'b0, 1'b0, 1'b1, 1'b0, RV,    0};

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      drive(1'($urandom), $urandom, 1'($urandom), 1'($urandom));
      chk_rst();
      tick();
    end
    #2 reset = 1'b1;

    // Streaming, back-pressure, full+simultaneous, flush
    for (int i = 0; i < 23; i++) begin
      drive(tv[i].iv, tv[i].id, tv[i].ordy, tv[i].fl);
      chk($sformatf("tv%0d.in_ready", i), 32'(ir3), 32'(tv[i].e_ir));
      chk($sformatf("tv%0d.out_valid", i), 32'(ov3), 32'(tv[i].e_ov));
      chk($sformatf("tv%0d.out_data", i), od3, tv[i].e_od);
      chk($sformatf("tv%0d.count", i), 32'(cnt3), 32'(tv[i].e_cnt));
      tick();
    end

    // Bubble collapse on the 4-deep line with the output stalled
    drive(1'b1, 32'h100, 1'b0, 1'b0); tick();
    drive(1'b0, 32'h0,   1'b0, 1'b0); tick();
    drive(1'b1, 32'h200, 1'b0, 1'b0); tick();
    drive(1'b0, 32'h0,   1'b0, 1'b0); tick();
    drive(1'b0, 32'h0,   1'b0, 1'b0); tick();
    drive(1'b0, 32'h0,   1'b0, 1'b0);
    chk("bub.count", 32'(cnt4), 32'd2);
    chk("bub.out_valid", 32'(ov4), 32'd1);
    chk("bub.out_data", od4, 32'h100);
    chk("bub.in_ready", 32'(ir4), 32'd1);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("bub.next_data", od4, 32'h200);
    chk("bub.next_valid", 32'(ov4), 32'd1);
    chk("bub.next_count", 32'(cnt4), 32'd1);
    tick();

    // Randomized traffic with flushes and one async reset
    for (int i = 0; i < 3000; i++) begin
      logic ordy;
      if ((i % 400) < 200) ordy = ($urandom_range(0, 3) == 0);
      else ordy = ($urandom_range(0, 3) != 0);
      drive($urandom_range(0, 3) != 0, $urandom, ordy,
            $urandom_range(0, 40) == 0);
      tick();
      if (i == 1234) begin
        #2 reset = 1'b0;
        mclear(0);
        mclear(1);
        #1 chk_rst();
        #1 reset = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
